sync_debounce: RTL and testbench

- Sits directly downstream of the two-flop reset-to-low synchronizer and consumes its synchronized output.
- Filters glitches: the debounced level changes only after the input holds a new value for STABLE_CYCLES consecutive sampled edges.
- Emits one-cycle rise and fall strobes for downstream control logic, such as the FIR accelerator start/mode handling.
- Purely synchronous, single clock domain.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_counter.sv | 34 +++
 rtl/sync_debounce.sv | 134 +++++++++++++
 tb/tb_sync_debounce.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the synchronized-input debouncer.
// Holds the FSM state encoding and default sizing constants.
// No logic; imported by the debouncer and its counter.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'b00,
        CHECK_HIGH = 2'b01,
        IDLE_HIGH  = 2'b10,
        CHECK_LOW  = 2'b11
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_WIDTH     = 8;

endpackage

// File: rtl/debounce_counter.sv
// Stability counter: clears, increments, and flags count == STABLE_CYCLES-1.
// Latency: count updates one edge after clr/inc; the match flag is combinational on the count.
// No backpressure; the caller gates clr/inc (clear wins over increment).
module debounce_counter
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_match
);

    localparam logic [CNT_WIDTH-1:0] MATCH_VAL = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Counter register: the FSM never increments past MATCH_VAL, so no wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_match = (r_cnt == MATCH_VAL);

endmodule

// File: rtl/sync_debounce.sv
// Debounces a synchronized level and emits one-cycle rise/fall strobes.
// Latency: output follows STABLE_CYCLES-1 edges after the new level is first sampled.
// No backpressure; en=0 freezes all state and suppresses strobes.
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    // Reject parameter sets where the counter could not reach its match value.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > ((1 << CNT_WIDTH) - 1)) begin : g_bad_param
        $error("sync_debounce: STABLE_CYCLES out of range for CNT_WIDTH");
    end

    state_t r_state;
    logic   r_db;
    logic   r_rise;
    logic   r_fall;
    logic   r_busy;
    logic   w_clr;
    logic   w_inc;
    logic   w_match;

    // Counter control: entering a check counts from 0 to 1; abort or completion clears.
    always_comb begin
        w_clr = 1'b0;
        w_inc = 1'b0;
        if (en) begin
            case (r_state)
                IDLE_LOW: begin
                    w_inc = sync_in;
                    w_clr = ~sync_in;
                end
                CHECK_HIGH: begin
                    w_clr = ~sync_in | w_match;
                    w_inc = sync_in & ~w_match;
                end
                IDLE_HIGH: begin
                    w_inc = ~sync_in;
                end
                CHECK_LOW: begin
                    w_clr = sync_in | w_match;
                    w_inc = ~sync_in & ~w_match;
                end
                default: begin
                    w_clr = 1'b1;
                end
            endcase
        end
    end

    debounce_counter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_match (w_match)
    );

    // FSM with registered level, strobes and busy; strobes default low every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (en) begin
                case (r_state)
                    IDLE_LOW: begin
                        if (sync_in) begin
                            r_state <= CHECK_HIGH;
                            r_busy  <= 1'b1;
                        end
                    end
                    CHECK_HIGH: begin
                        if (!sync_in) begin
                            r_state <= IDLE_LOW;
                            r_busy  <= 1'b0;
                        end else if (w_match) begin
                            r_state <= IDLE_HIGH;
                            r_db    <= 1'b1;
                            r_rise  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    IDLE_HIGH: begin
                        if (!sync_in) begin
                            r_state <= CHECK_LOW;
                            r_busy  <= 1'b1;
                        end
                    end
                    CHECK_LOW: begin
                        if (sync_in) begin
                            r_state <= IDLE_HIGH;
                            r_busy  <= 1'b0;
                        end else if (w_match) begin
                            r_state <= IDLE_LOW;
                            r_db    <= 1'b0;
                            r_fall  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE_LOW;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign db_out     = r_db;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed scenarios plus randomized stimulus.
// Reference: debounced level plus length of the current run of enabled samples differing from it.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sync_debounce;

    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sync_in;
    logic db_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic m_db  = 1'b0;
    int   m_run = 0;
    int   n_rise;
    int   n_fall;
    logic last_was_rise;
    logic alt_ok;

    always #5 clk = ~clk;

    sync_debounce #(
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync_in    (sync_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one edge, advance the model, and compare every output.
    task automatic step(input logic r, input logic e, input logic s, input string tag);
        logic exp_rise;
        logic exp_fall;
        rst = r;
        en = e;
        sync_in = s;
        @(posedge clk);
        #1;
        exp_rise = 1'b0;
        exp_fall = 1'b0;
        if (r) begin
            m_db  = 1'b0;
            m_run = 0;
        end else if (e) begin
            if (s != m_db) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_db  = s;
                    m_run = 0;
                    if (s) exp_rise = 1'b1;
                    else   exp_fall = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
        check({tag, ".db"},   {31'd0, db_out},     {31'd0, m_db});
        check({tag, ".rise"}, {31'd0, rise_pulse}, {31'd0, exp_rise});
        check({tag, ".fall"}, {31'd0, fall_pulse}, {31'd0, exp_fall});
        check({tag, ".busy"}, {31'd0, busy},       {31'd0, (m_run != 0)});
        if (rise_pulse) begin
            n_rise++;
            if (last_was_rise) alt_ok = 1'b0;
            last_was_rise = 1'b1;
        end
        if (fall_pulse) begin
            n_fall++;
            if (!last_was_rise) alt_ok = 1'b0;
            last_was_rise = 1'b0;
        end
    endtask

    initial begin
        logic lvl;
        rst = 1'b1;
        en = 1'b1;
        sync_in = 1'b1;

        // Reset held two cycles with sync_in high, then first edge after release
        step(1'b1, 1'b1, 1'b1, "reset0");
        step(1'b1, 1'b1, 1'b1, "reset1");
        step(1'b0, 1'b1, 1'b0, "post_reset");

        // Clean rise: busy from edge k, db/rise at k+3, rise clears at k+4
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, "clean_rise");

        // Glitch from IDLE_HIGH: 2-edge low then back high
        step(1'b0, 1'b1, 1'b0, "glitch_lo");
        step(1'b0, 1'b1, 1'b0, "glitch_lo");
        step(1'b0, 1'b1, 1'b1, "glitch_lo_end");
        step(1'b0, 1'b1, 1'b1, "glitch_lo_end");

        // Fall back down, then glitch from IDLE_LOW: 3 high then low
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, "clean_fall");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, "glitch_hi");
        step(1'b0, 1'b1, 1'b0, "glitch_hi_end");

        // Enable freeze: 2 qualifying edges, 5 frozen (with an unseen glitch), then resume
        step(1'b0, 1'b1, 1'b1, "freeze_pre");
        step(1'b0, 1'b1, 1'b1, "freeze_pre");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, (i == 2) ? 1'b0 : 1'b1, "freeze");
        step(1'b0, 1'b1, 1'b1, "freeze_post");
        step(1'b0, 1'b1, 1'b1, "freeze_post");
        step(1'b0, 1'b1, 1'b1, "freeze_post");

        // Mid-check reset in CHECK_LOW with count=2
        step(1'b0, 1'b1, 1'b0, "midrst_pre");
        step(1'b0, 1'b1, 1'b0, "midrst_pre");
        step(1'b1, 1'b1, 1'b0, "midrst");
        step(1'b0, 1'b1, 1'b0, "midrst_post");

        // Back-to-back: 20 periods of 4 stable edges each
        n_rise = 0;
        n_fall = 0;
        last_was_rise = 1'b0;
        alt_ok = 1'b1;
        lvl = 1'b0;
        for (int p = 0; p < 20; p++) begin
            lvl = ~lvl;
            for (int i = 0; i < 4; i++) step(1'b0, 1'b1, lvl, "b2b");
        end
        check("b2b_rise_count", n_rise, 10);
        check("b2b_fall_count", n_fall, 10);
        check("b2b_alternate", {31'd0, alt_ok}, 1);

        // Randomized: bursty input with occasional freezes and resets
        lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) lvl = ~lvl;
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                 lvl, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
